trigger_sequencer_of_verifla: RTL and testbench

- Multi-stage trigger controller that sits beside the capture monitor.
- Sources the monitor's trigqual and exttrig inputs; watches its armed and triggered outputs.
- Host-side configuration (from the UART command decoder) programs up to MAX_STAGES ordered match stages, each with mask, value and occurrence count.
- The monitor's trigger fires only after all stages complete in order. With zero stages programmed, the block is transparent and the monitor uses its built-in trigger.

---
 rtl/trigger_sequencer_of_verifla_pkg.sv | 25 ++
 rtl/trigger_sequencer_of_verifla_stage_regs.sv | 84 ++++++++
 rtl/trigger_sequencer_of_verifla.sv | 170 +++++++++++++++++
 tb/tb_trigger_sequencer_of_verifla.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_sequencer_of_verifla_pkg.sv
// Shared definitions for the multi-stage trigger sequencer: FSM encodings,
// configuration register offsets and the num_stages register address.
package trigger_sequencer_of_verifla_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_MATCH = 2'd1,
    SEQ_FIRE  = 2'd2,
    SEQ_HOLD  = 2'd3
  } seq_state_t;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_VALUE   = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  function automatic int reg_num_stages(input int max_stages);
    return 4 * max_stages;
  endfunction

  function automatic int max_bits(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trigger_sequencer_of_verifla_stage_regs.sv
// Stage configuration register file with write-accept and cfg_err logic.
// Per-stage timeout registers exist only when LA_TRIGSEQ_TIMEOUT_EN is defined.
module trigseq_stage_regs
  import trigger_sequencer_of_verifla_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int MAX_STAGES    = 4,
  parameter int COUNT_BITS    = 16,
  parameter int CFG_ADDR_BITS = 5,
  parameter int WDATA_BITS    = 16,
  parameter int SIDX          = 2
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     idle,
  input  logic                     cfg_wen,
  input  logic [CFG_ADDR_BITS-1:0] cfg_addr,
  input  logic [WDATA_BITS-1:0]    cfg_wdata,
  input  logic [SIDX-1:0]          sel,
  output logic [DATA_BITS-1:0]     mask,
  output logic [DATA_BITS-1:0]     value,
  output logic [COUNT_BITS-1:0]    count,
`ifdef LA_TRIGSEQ_TIMEOUT_EN
  output logic [COUNT_BITS-1:0]    timeout,
`endif
  output logic [3:0]               num_stages,
  output logic                     cfg_err
);

  localparam logic [CFG_ADDR_BITS-1:0] NUM_ADDR = CFG_ADDR_BITS'(reg_num_stages(MAX_STAGES));

  logic [DATA_BITS-1:0]  mask_r  [MAX_STAGES];
  logic [DATA_BITS-1:0]  value_r [MAX_STAGES];
  logic [COUNT_BITS-1:0] count_r [MAX_STAGES];
`ifdef LA_TRIGSEQ_TIMEOUT_EN
  logic [COUNT_BITS-1:0] tmo_r   [MAX_STAGES];
`endif

  logic [SIDX-1:0] wsel;
  logic [3:0]      wnum;
  assign wsel = cfg_addr[SIDX+1:2];
  assign wnum = cfg_wdata[3:0];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int s = 0; s < MAX_STAGES; s++) begin
        mask_r[s]  <= '0;
        value_r[s] <= '0;
        count_r[s] <= '0;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
        tmo_r[s]   <= '0;
`endif
      end
      num_stages <= '0;
      cfg_err    <= 1'b0;
    end else begin
      // A write outside SEQ_IDLE is dropped and flagged one cycle later
      cfg_err <= cfg_wen && !idle;
      if (cfg_wen && idle) begin
        if (cfg_addr == NUM_ADDR) begin
          num_stages <= (wnum > 4'(MAX_STAGES)) ? 4'(MAX_STAGES) : wnum;
        end else if (cfg_addr < NUM_ADDR) begin
          case (cfg_addr[1:0])
            REG_MASK:    mask_r[wsel]  <= cfg_wdata[DATA_BITS-1:0];
            REG_VALUE:   value_r[wsel] <= cfg_wdata[DATA_BITS-1:0];
            REG_COUNT:   count_r[wsel] <= cfg_wdata[COUNT_BITS-1:0];
`ifdef LA_TRIGSEQ_TIMEOUT_EN
            REG_TIMEOUT: tmo_r[wsel]   <= cfg_wdata[COUNT_BITS-1:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign mask  = mask_r[sel];
  assign value = value_r[sel];
  assign count = count_r[sel];
`ifdef LA_TRIGSEQ_TIMEOUT_EN
  assign timeout = tmo_r[sel];
`endif

endmodule

// File: rtl/trigger_sequencer_of_verifla.sv
// Multi-stage trigger sequencer driving the capture monitor's trigqual/exttrig.
// Optional per-stage timeout restart is enabled by defining LA_TRIGSEQ_TIMEOUT_EN.
module trigger_sequencer_of_verifla
  import trigger_sequencer_of_verifla_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int MAX_STAGES    = 4,
  parameter int COUNT_BITS    = 16,
  parameter int CFG_ADDR_BITS = 5,
  parameter int WDATA_BITS    = max_bits(DATA_BITS, COUNT_BITS)
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     cqual,
  input  logic [DATA_BITS-1:0]     data_in,
  input  logic                     armed,
  input  logic                     triggered,
  input  logic                     cfg_wen,
  input  logic [CFG_ADDR_BITS-1:0] cfg_addr,
  input  logic [WDATA_BITS-1:0]    cfg_wdata,
  output logic                     trigqual,
  output logic                     exttrig,
  output logic [2:0]               seq_stage,
  output logic                     seq_busy,
  output logic                     cfg_err
);

  localparam int SIDX = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1;

  seq_state_t state, state_n;
  logic [2:0]            stage, stage_n;
  logic [COUNT_BITS-1:0] hits, hits_n;
  logic [DATA_BITS-1:0]  smp;
  logic [DATA_BITS-1:0]  mask, value;
  logic [COUNT_BITS-1:0] count, cnt_eff;
  logic [3:0]            num_stages;
  logic                  stage_match, hit_done, hit_last;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
  logic [COUNT_BITS-1:0] timeout, tmr, tmr_n, tmr_step;
`endif

  trigseq_stage_regs #(
    .DATA_BITS     (DATA_BITS),
    .MAX_STAGES    (MAX_STAGES),
    .COUNT_BITS    (COUNT_BITS),
    .CFG_ADDR_BITS (CFG_ADDR_BITS),
    .WDATA_BITS    (WDATA_BITS),
    .SIDX          (SIDX)
  ) u_regs (
    .clk        (clk),
    .rst_l      (rst_l),
    .idle       (state == SEQ_IDLE),
    .cfg_wen    (cfg_wen),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .sel        (stage[SIDX-1:0]),
    .mask       (mask),
    .value      (value),
    .count      (count),
`ifdef LA_TRIGSEQ_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .num_stages (num_stages),
    .cfg_err    (cfg_err)
  );

  // smp lags data_in by one qualified sample, in step with the monitor
  assign stage_match = ((smp & mask) == (value & mask));
  assign cnt_eff     = (count == '0) ? COUNT_BITS'(1) : count;
  assign hit_done    = ((hits + COUNT_BITS'(1)) == cnt_eff);
  assign hit_last    = ({1'b0, stage} == (num_stages - 4'd1));

  always_comb begin
    state_n = state;
    stage_n = stage;
    hits_n  = hits;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
    tmr_n    = tmr;
    tmr_step = (stage != 3'd0) ? tmr + COUNT_BITS'(1) : tmr;
`endif
    case (state)
      SEQ_IDLE: begin
        if (armed && (num_stages != 4'd0)) begin
          state_n = SEQ_MATCH;
          stage_n = 3'd0;
          hits_n  = '0;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
          tmr_n   = '0;
`endif
        end
      end
      SEQ_MATCH: begin
        // Abort takes priority over any match in the same cycle
        if (!armed) begin
          state_n = SEQ_IDLE;
          stage_n = 3'd0;
        end else if (cqual) begin
`ifdef LA_TRIGSEQ_TIMEOUT_EN
          tmr_n = tmr_step;
`endif
          if (stage_match) begin
            if (hit_done && hit_last) begin
              state_n = SEQ_FIRE;
            end else if (hit_done) begin
              stage_n = stage + 3'd1;
              hits_n  = '0;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
              tmr_n   = '0;
`endif
            end else begin
              hits_n = hits + COUNT_BITS'(1);
            end
          end
`ifdef LA_TRIGSEQ_TIMEOUT_EN
          else if ((stage != 3'd0) && (timeout != '0) && (tmr_step >= timeout)) begin
            stage_n = 3'd0;
            hits_n  = '0;
            tmr_n   = '0;
          end
`endif
        end
      end
      SEQ_FIRE: begin
        if (!armed) begin
          state_n = SEQ_IDLE;
          stage_n = 3'd0;
        end else if (triggered) begin
          state_n = SEQ_HOLD;
        end
      end
      SEQ_HOLD: begin
        if (!armed) begin
          state_n = SEQ_IDLE;
          stage_n = 3'd0;
        end
      end
      default: begin
        state_n = SEQ_IDLE;
        stage_n = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state   <= SEQ_IDLE;
      stage   <= 3'd0;
      hits    <= '0;
      smp     <= '0;
      exttrig <= 1'b0;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
      tmr     <= '0;
`endif
    end else begin
      state   <= state_n;
      stage   <= stage_n;
      hits    <= hits_n;
      exttrig <= (state_n == SEQ_FIRE);
`ifdef LA_TRIGSEQ_TIMEOUT_EN
      tmr     <= tmr_n;
`endif
      if (cqual) smp <= data_in;
    end
  end

  assign trigqual  = (num_stages == 4'd0);
  assign seq_busy  = (state != SEQ_IDLE);
  assign seq_stage = stage;

endmodule

// File: tb/tb_trigger_sequencer_of_verifla.sv
// Randomized self-checking bench for trigger_sequencer_of_verifla against a
// progress-count reference model (cumulative occurrence counts per stage).
module tb_trigger_sequencer_of_verifla;

  logic        clk, rst_l, cqual, armed, triggered, cfg_wen;
  logic [7:0]  data_in;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        trigqual, exttrig, seq_busy, cfg_err;
  logic [2:0]  seq_stage;

  trigger_sequencer_of_verifla dut (
    .clk(clk), .rst_l(rst_l), .cqual(cqual), .data_in(data_in),
    .armed(armed), .triggered(triggered), .cfg_wen(cfg_wen),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .trigqual(trigqual),
    .exttrig(exttrig), .seq_stage(seq_stage), .seq_busy(seq_busy),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [6:0] obs = {trigqual, exttrig, seq_stage, seq_busy, cfg_err};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress = qualified matches consumed since arming.
  int m_mask [4], m_val [4], m_cnt [4], m_to [4];
  int m_num, m_phase, m_prog, m_tmr, m_smp;  // phase: 0 idle 1 match 2 fire 3 hold
  bit m_err;

  function automatic int eff(input int s);
    return (m_cnt[s] == 0) ? 1 : m_cnt[s];
  endfunction

  function automatic int stage_of(input int p);
    int c = 0;
    for (int s = 0; s < m_num; s++) begin
      c += eff(s);
      if (p < c) return s;
    end
    return m_num;
  endfunction

  function automatic logic [6:0] exp_vec();
    int st;
    st = (m_phase == 1) ? stage_of(m_prog) : (m_phase == 0) ? 0 : m_num - 1;
    return {(m_num == 0), (m_phase == 2), 3'(st), (m_phase != 0), m_err};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_mask[s] = 0; m_val[s] = 0; m_cnt[s] = 0; m_to[s] = 0;
    end
    m_num = 0; m_phase = 0; m_prog = 0; m_tmr = 0; m_smp = 0; m_err = 0;
  endtask

  task automatic model_step(input bit arm, input bit cq, input int d, input bit trig,
                            input bit wen, input int addr, input int wd);
    bit was_idle, m;
    int s, sn;
    was_idle = (m_phase == 0);
    m_err = wen && !was_idle;
    case (m_phase)
      0: if (arm && m_num != 0) begin m_phase = 1; m_prog = 0; m_tmr = 0; end
      1: if (!arm) m_phase = 0;
         else if (cq) begin
           s = stage_of(m_prog);
           m = ((m_smp & m_mask[s]) == (m_val[s] & m_mask[s]));
           if (m) begin
             m_prog++;
             sn = stage_of(m_prog);
             if (sn == m_num) m_phase = 2;
             else if (sn != s) m_tmr = 0;
             else if (s > 0) m_tmr++;
           end else if (s > 0) begin
             m_tmr++;
`ifdef LA_TRIGSEQ_TIMEOUT_EN
             if (m_to[s] != 0 && m_tmr >= m_to[s]) begin
               m_prog = 0 + (stage_of(0) == 0 ? 0 : 0);
               m_tmr = 0;
             end
`endif
           end
         end
      2: if (!arm) m_phase = 0; else if (trig) m_phase = 3;
      default: if (!arm) m_phase = 0;
    endcase
    if (cq) m_smp = d & 255;
    if (wen && was_idle) begin
      if (addr == 16) m_num = ((wd & 15) > 4) ? 4 : (wd & 15);
      else if (addr < 16) begin
        case (addr % 4)
          0: m_mask[addr / 4] = wd & 255;
          1: m_val[addr / 4]  = wd & 255;
          2: m_cnt[addr / 4]  = wd & 65535;
          default: begin
`ifdef LA_TRIGSEQ_TIMEOUT_EN
            m_to[addr / 4] = wd & 65535;
`endif
          end
        endcase
      end
    end
  endtask

  task automatic cycle(input bit arm, input bit cq, input int d, input bit trig,
                       input bit wen = 0, input int addr = 0, input int wd = 0);
    armed = arm; cqual = cq; data_in = 8'(d); triggered = trig;
    cfg_wen = wen; cfg_addr = 5'(addr); cfg_wdata = 16'(wd);
    @(posedge clk);
    model_step(arm, cq, d, trig, wen, addr, wd);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    cycle(1, 1, 8'h5a, 1, 1, 16, 3);
    model_reset();
    rst_l = 1'b1;
    n_cmp++;
    if (obs !== 7'b1_0_000_0_0) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", obs, 7'b1_0_000_0_0);
    end
  endtask

  task automatic test_transparent();
    cycle(0, 1, 0, 0, 1, 16, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1'($urandom_range(1)), (i % 3 == 0) ? 8'haa : int'($urandom_range(255)), 0);
      n_cmp++;
      if (obs !== exp_vec() || trigqual !== 1'b1 || exttrig !== 1'b0) begin
        n_bad++;
        $display("FAIL transparent[%0d]: got %b want %b", i, obs, exp_vec());
      end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_two_stage();
    int wa [7] = '{0, 1, 2, 4, 5, 6, 16};
    int wv [7] = '{8'hff, 8'h11, 1, 8'hff, 8'h22, 3, 2};
    int dv [8] = '{8'h00, 8'h11, 8'h22, 8'h05, 8'h22, 8'h22, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 1, wa[i], wv[i]);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, dv[i], 0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL two_stage[%0d]: got %b want %b", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (exttrig !== 1'b1 || seq_stage !== 3'd1) begin
      n_bad++;
      $display("FAIL two_stage_fire: got ext=%b stage=%0d want ext=1 stage=1", exttrig, seq_stage);
    end
    cycle(1, 1, 0, 1);
    n_cmp++;
    if (obs !== exp_vec() || exttrig !== 1'b0 || seq_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL two_stage_hold: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_cqual();
    cycle(0, 1, 0, 0, 1, 0, 8'hff);
    cycle(0, 1, 0, 0, 1, 1, 8'h11);
    cycle(0, 1, 0, 0, 1, 2, 2);
    cycle(0, 1, 0, 0, 1, 16, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, (i % 2 == 0), 8'h11, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL cqual[%0d]: got %b want %b", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (exttrig !== 1'b1) begin
      n_bad++;
      $display("FAIL cqual_fire: got ext=%b want 1", exttrig);
    end
  endtask

  task automatic test_abort();
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (obs !== exp_vec() || exttrig !== 1'b0 || seq_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_cfg_busy();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0, 1, 1, 8'h33);
    n_cmp++;
    if (obs !== exp_vec() || cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_busy_err: got %b want %b", obs, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cycle(i < 3, 1, 8'h11, 0);
      n_cmp++;
      if (obs !== exp_vec() || cfg_err !== 1'b0 || exttrig !== (i == 2)) begin
        n_bad++;
        $display("FAIL cfg_busy_after[%0d]: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

`ifdef LA_TRIGSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int wa [8] = '{0, 1, 2, 4, 5, 6, 7, 16};
    int wv [8] = '{8'hff, 8'h11, 1, 8'hff, 8'h22, 1, 4, 2};
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 1, wa[i], wv[i]);
    cycle(1, 1, 8'h11, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 8'h05, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (seq_stage !== 3'd0 || seq_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_restart: got stage=%0d busy=%b want stage=0 busy=1", seq_stage, seq_busy);
    end
    cycle(0, 1, 0, 0);
  endtask
`endif

  task automatic test_random();
    int masks [5] = '{8'hff, 8'hf0, 8'h0f, 8'h00, 8'h03};
    int d;
    for (int t = 0; t < 40; t++) begin
      cycle(0, 1, 0, 0);
      for (int s = 0; s < 4; s++) begin
        cycle(0, 1, 0, 0, 1, 4 * s, masks[$urandom_range(4)]);
        cycle(0, 1, 0, 0, 1, 4 * s + 1, $urandom_range(255));
        cycle(0, 1, 0, 0, 1, 4 * s + 2, $urandom_range(3));
        cycle(0, 1, 0, 0, 1, 4 * s + 3, $urandom_range(6));
      end
      cycle(0, 1, 0, 0, 1, 17 + $urandom_range(14), $urandom);
      cycle(0, 1, 0, 0, 1, 16, $urandom_range(15));
      for (int i = 0; i < 40; i++) begin
        d = ($urandom_range(1) == 1) ? m_val[$urandom_range(3)] : int'($urandom_range(255));
        cycle(($urandom_range(99) >= 3), ($urandom_range(3) != 0), d,
              ($urandom_range(4) == 0), ($urandom_range(19) == 0),
              $urandom_range(31), $urandom);
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_bad++;
          $display("FAIL random[%0d.%0d]: got %b want %b", t, i, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst_l = 1'b0; armed = 0; cqual = 0; triggered = 0; cfg_wen = 0;
    data_in = '0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    test_reset();
    test_transparent();
    test_two_stage();
    test_reset();
    test_cqual();
    test_abort();
    test_cfg_busy();
`ifdef LA_TRIGSEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
